// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: operation codes
// and their encoding width.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_ANDN   = 3'd3;
  localparam logic [OP_W-1:0] OP_ORN    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_REDAND = 3'd6;
  localparam logic [OP_W-1:0] OP_REDOR  = 3'd7;

endpackage

// File: rtl/logic_unit_stage.sv
// One elastic pipeline slice: a valid bit plus result and tag registers.
// Payload only moves when a valid op enters, so an emptied slice keeps its last value.
module logic_unit_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  input  logic [TAG_W-1:0] d_tag,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data,
  output logic [TAG_W-1:0] q_tag
);

  // NOTE: sequential state uses non-blocking assignments so every slice
  // samples its upstream neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload registers are reset too, because out_data/out_tag
      // must read zero after reset rather than stale contents.
      q_valid <= 1'b0;
      q_data  <= '0;
      q_tag   <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      if (d_valid) begin
        q_data <= d_data;
        q_tag  <= d_tag;
      end
    end
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// WIDTH-bit bitwise logic unit with an elastic valid/ready pipeline of STAGES
// slices; the result is computed at the input and the slices only carry it.
module pipelined_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic [WIDTH-1:0]  result;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] advance;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [TAG_W-1:0]  stage_tag  [STAGES];

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    result = '0;
    case (in_op)
      OP_AND:    result = in_a & in_b;
      OP_OR:     result = in_a | in_b;
      OP_XOR:    result = in_a ^ in_b;
      OP_ANDN:   result = in_a & ~in_b;
      OP_ORN:    result = in_a | ~in_b;
      OP_XNOR:   result = ~(in_a ^ in_b);
      OP_REDAND: result[0] = &in_a;
      OP_REDOR:  result[0] = |in_a;
      default:   result = '0;
    endcase
  end

  // A slice may load when it, or any slice downstream of it, has room, or the
  // consumer is taking the head; walking from the output keeps this acyclic.
  always_comb begin : advance_chain
    logic room;
    room    = out_ready;
    advance = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room       = room | ~stage_valid[k];
      advance[k] = room;
    end
  end

  assign in_ready = ~flush & advance[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic [TAG_W-1:0] up_tag;

    if (g == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = result;
      assign up_tag   = in_tag;
    end else begin : g_body
      assign up_valid = stage_valid[g-1];
      assign up_data  = stage_data[g-1];
      assign up_tag   = stage_tag[g-1];
    end

    logic_unit_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .load    (advance[g]),
      .d_valid (up_valid),
      .d_data  (up_data),
      .d_tag   (up_tag),
      .q_valid (stage_valid[g]),
      .q_data  (stage_data[g]),
      .q_tag   (stage_tag[g])
    );
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];
  assign out_tag   = stage_tag[STAGES-1];
  assign busy      = |stage_valid;

endmodule
